// File: rtl/zeroriscy_dual_soc.sv
// Dual-hart sum-of-1..N_TERMS SoC with one arbitrated write port into a 2-word data memory.
// Define LOCKSTEP_CHECK_EN to build the result comparator that drives mem_flag[3:2].
module zeroriscy_dual_soc #(
    parameter logic [31:0] BOOT_ADDR1 = 32'h0000_0080,
    parameter logic [31:0] BOOT_ADDR2 = 32'h0000_1080,
    parameter int          N_TERMS    = 10
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fetch_enable_i_1,
    input  logic        fetch_enable_i_2,
    output logic [31:0] mem_flag,
    output logic [31:0] mem_result,
    output logic [31:0] instr_addr1,
    output logic [31:0] instr_addr2
);

    localparam logic [15:0] LAST_CNT = 16'(N_TERMS);

    logic [31:0] pc      [2];
    logic [31:0] acc     [2];
    logic [15:0] cnt     [2];
    logic [15:0] cnt_next[2];
    logic [1:0]  done;
    logic [1:0]  pending;
    logic [1:0]  enable;
    logic [1:0]  grant;
    logic [1:0]  written;
    logic [31:0] wr_data;
    logic        cmp_match;
    logic        cmp_mismatch;

    assign enable      = {fetch_enable_i_2, fetch_enable_i_1};
    assign instr_addr1 = pc[0];
    assign instr_addr2 = pc[1];

    // Hart 1 has fixed priority; grant is one-hot or zero.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        grant       = 2'b00;
        wr_data     = acc[1];
        cnt_next[0] = cnt[0] + 16'd1;
        cnt_next[1] = cnt[1] + 16'd1;
        if (pending[0]) begin
            grant[0] = 1'b1;
            wr_data  = acc[0];
        end else if (pending[1]) begin
            grant[1] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc[0]   <= BOOT_ADDR1;
            pc[1]   <= BOOT_ADDR2;
            done    <= 2'b00;
            pending <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                acc[i] <= '0;
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (enable[i] && !done[i]) begin
                    cnt[i] <= cnt_next[i];
                    acc[i] <= acc[i] + {16'b0, cnt_next[i]};
                    pc[i]  <= pc[i] + 32'd4;
                    if (cnt_next[i] == LAST_CNT) begin
                        done[i]    <= 1'b1;
                        pending[i] <= 1'b1;
                    end
                end
                if (grant[i]) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            written    <= 2'b00;
            mem_result <= '0;
        end else if (|grant) begin
            written    <= written | grant;
            mem_result <= wr_data;
        end
    end

`ifdef LOCKSTEP_CHECK_EN
    logic [31:0] dmem[2];
    logic        wr_idx;

    assign wr_idx = grant[1];

    // NOTE: the 2-word memory is reset because the comparator reads it; larger RAMs would not be.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dmem[0]      <= '0;
            dmem[1]      <= '0;
            cmp_match    <= 1'b0;
            cmp_mismatch <= 1'b0;
        end else if (|grant) begin
            dmem[wr_idx] <= wr_data;
            // The other hart already wrote, so this is the second write: compare against its word.
            if (written[~wr_idx]) begin
                if (wr_data == dmem[~wr_idx]) begin
                    cmp_match <= 1'b1;
                end else begin
                    cmp_mismatch <= 1'b1;
                end
            end
        end
    end
`else
    assign cmp_match    = 1'b0;
    assign cmp_mismatch = 1'b0;
`endif

    assign mem_flag = {28'b0, cmp_mismatch, cmp_match, written};

endmodule

// File: tb/tb_zeroriscy_dual_soc.sv
// Directed self-checking bench for zeroriscy_dual_soc (default instance plus an N_TERMS=1 instance).
module tb_zeroriscy_dual_soc;

`ifdef LOCKSTEP_CHECK_EN
    localparam logic [31:0] FLAG_BOTH = 32'h7;
`else
    localparam logic [31:0] FLAG_BOTH = 32'h3;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        en1;
    logic        en2;
    logic [31:0] flag, result, addr1, addr2;
    logic [31:0] n1_flag, n1_result, n1_addr1, n1_addr2;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    zeroriscy_dual_soc dut (
        .clk_i(clk), .rst_i(rst), .fetch_enable_i_1(en1), .fetch_enable_i_2(en2),
        .mem_flag(flag), .mem_result(result), .instr_addr1(addr1), .instr_addr2(addr2)
    );

    zeroriscy_dual_soc #(.N_TERMS(1)) dut_n1 (
        .clk_i(clk), .rst_i(rst), .fetch_enable_i_1(en1), .fetch_enable_i_2(en2),
        .mem_flag(n1_flag), .mem_result(n1_result), .instr_addr1(n1_addr1), .instr_addr2(n1_addr2)
    );

    // Outputs are sampled and inputs driven 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input logic e1, input logic e2);
        rst = 1'b1;
        en1 = e1;
        en2 = e2;
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [31:0] exp_addr(input logic [31:0] boot, input int steps);
        return boot + 32'(4 * ((steps > 10) ? 10 : ((steps < 0) ? 0 : steps)));
    endfunction

    task automatic test_reset();
        apply_reset(1'b0, 1'b0);
        checks++; if (addr1 !== 32'h80) begin errors++; $display("FAIL reset_addr1 got=%h exp=%h", addr1, 32'h80); end
        checks++; if (addr2 !== 32'h1080) begin errors++; $display("FAIL reset_addr2 got=%h exp=%h", addr2, 32'h1080); end
        checks++; if (flag !== 32'h0) begin errors++; $display("FAIL reset_flag got=%h exp=0", flag); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=0", result); end
    endtask

    task automatic test_basic();
        logic [31:0] ef, er;
        apply_reset(1'b1, 1'b1);
        for (int e = 1; e <= 14; e++) begin
            tick();
            ef = (e < 11) ? 32'h0 : ((e == 11) ? 32'h1 : FLAG_BOTH);
            er = (e < 11) ? 32'd0 : 32'd55;
            checks++; if (addr1 !== exp_addr(32'h80, e)) begin errors++; $display("FAIL basic_addr1 edge=%0d got=%h exp=%h", e, addr1, exp_addr(32'h80, e)); end
            checks++; if (addr2 !== exp_addr(32'h1080, e)) begin errors++; $display("FAIL basic_addr2 edge=%0d got=%h exp=%h", e, addr2, exp_addr(32'h1080, e)); end
            checks++; if (flag !== ef) begin errors++; $display("FAIL basic_flag edge=%0d got=%h exp=%h", e, flag, ef); end
            checks++; if (result !== er) begin errors++; $display("FAIL basic_result edge=%0d got=%0d exp=%0d", e, result, er); end
        end
    endtask

    task automatic test_stall_hart2();
        logic [31:0] ef;
        apply_reset(1'b1, 1'b0);
        for (int e = 1; e <= 17; e++) begin
            en2 = (e > 5);
            tick();
            ef = (e < 11) ? 32'h0 : ((e < 16) ? 32'h1 : FLAG_BOTH);
            checks++; if (addr2 !== exp_addr(32'h1080, e - 5)) begin errors++; $display("FAIL stall_addr2 edge=%0d got=%h exp=%h", e, addr2, exp_addr(32'h1080, e - 5)); end
            checks++; if (flag !== ef) begin errors++; $display("FAIL stall_flag edge=%0d got=%h exp=%h", e, flag, ef); end
        end
        checks++; if (result !== 32'd55) begin errors++; $display("FAIL stall_result got=%0d exp=55", result); end
    endtask

    task automatic test_toggle_hart1();
        logic [31:0] ef;
        apply_reset(1'b1, 1'b1);
        for (int e = 1; e <= 22; e++) begin
            en1 = e[0];
            tick();
            ef = (e < 11) ? 32'h0 : ((e < 20) ? 32'h2 : FLAG_BOTH);
            checks++; if (addr1 !== exp_addr(32'h80, (e + 1) / 2)) begin errors++; $display("FAIL toggle_addr1 edge=%0d got=%h exp=%h", e, addr1, exp_addr(32'h80, (e + 1) / 2)); end
            checks++; if (flag !== ef) begin errors++; $display("FAIL toggle_flag edge=%0d got=%h exp=%h", e, flag, ef); end
        end
        checks++; if (result !== 32'd55) begin errors++; $display("FAIL toggle_result got=%0d exp=55", result); end
        checks++; if (addr1 !== 32'hA8) begin errors++; $display("FAIL toggle_final_addr1 got=%h exp=%h", addr1, 32'hA8); end
    endtask

    task automatic test_mid_reset();
        logic [31:0] ef;
        int          r;
        apply_reset(1'b1, 1'b1);
        for (int e = 1; e <= 5; e++) tick();
        checks++; if (addr1 !== 32'h94) begin errors++; $display("FAIL midrst_pre_addr1 got=%h exp=%h", addr1, 32'h94); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (addr1 !== 32'h80) begin errors++; $display("FAIL midrst_addr1 got=%h exp=%h", addr1, 32'h80); end
        checks++; if (addr2 !== 32'h1080) begin errors++; $display("FAIL midrst_addr2 got=%h exp=%h", addr2, 32'h1080); end
        checks++; if (flag !== 32'h0) begin errors++; $display("FAIL midrst_flag got=%h exp=0", flag); end
        for (int e = 7; e <= 19; e++) begin
            tick();
            r  = e - 6;
            ef = (r < 11) ? 32'h0 : ((r == 11) ? 32'h1 : FLAG_BOTH);
            checks++; if (addr2 !== exp_addr(32'h1080, r)) begin errors++; $display("FAIL rerun_addr2 edge=%0d got=%h exp=%h", e, addr2, exp_addr(32'h1080, r)); end
            checks++; if (flag !== ef) begin errors++; $display("FAIL rerun_flag edge=%0d got=%h exp=%h", e, flag, ef); end
        end
        checks++; if (result !== 32'd55) begin errors++; $display("FAIL rerun_result got=%0d exp=55", result); end
    endtask

    task automatic test_write_abort();
        apply_reset(1'b1, 1'b1);
        for (int e = 1; e <= 11; e++) tick();
        checks++; if (flag !== 32'h1) begin errors++; $display("FAIL abort_pre_flag got=%h exp=1", flag); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        en1 = 1'b0;
        en2 = 1'b0;
        checks++; if (flag !== 32'h0) begin errors++; $display("FAIL abort_flag got=%h exp=0", flag); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL abort_result got=%0d exp=0", result); end
        for (int e = 0; e < 3; e++) tick();
        checks++; if (flag !== 32'h0) begin errors++; $display("FAIL abort_hold_flag got=%h exp=0", flag); end
        checks++; if (addr1 !== 32'h80) begin errors++; $display("FAIL abort_hold_addr1 got=%h exp=%h", addr1, 32'h80); end
    endtask

    task automatic test_single_term();
        apply_reset(1'b1, 1'b1);
        tick();
        checks++; if (n1_addr1 !== 32'h84) begin errors++; $display("FAIL n1_addr1 got=%h exp=%h", n1_addr1, 32'h84); end
        checks++; if (n1_flag !== 32'h0) begin errors++; $display("FAIL n1_flag_e1 got=%h exp=0", n1_flag); end
        tick();
        checks++; if (n1_flag !== 32'h1) begin errors++; $display("FAIL n1_flag_e2 got=%h exp=1", n1_flag); end
        checks++; if (n1_result !== 32'd1) begin errors++; $display("FAIL n1_result_e2 got=%0d exp=1", n1_result); end
        tick();
        checks++; if (n1_flag !== FLAG_BOTH) begin errors++; $display("FAIL n1_flag_e3 got=%h exp=%h", n1_flag, FLAG_BOTH); end
        checks++; if (n1_result !== 32'd1) begin errors++; $display("FAIL n1_result_e3 got=%0d exp=1", n1_result); end
        tick();
        checks++; if (n1_addr2 !== 32'h1084) begin errors++; $display("FAIL n1_addr2_hold got=%h exp=%h", n1_addr2, 32'h1084); end
    endtask

    task automatic test_idle();
        apply_reset(1'b0, 1'b0);
        for (int e = 0; e < 100; e++) tick();
        checks++; if (addr1 !== 32'h80) begin errors++; $display("FAIL idle_addr1 got=%h exp=%h", addr1, 32'h80); end
        checks++; if (addr2 !== 32'h1080) begin errors++; $display("FAIL idle_addr2 got=%h exp=%h", addr2, 32'h1080); end
        checks++; if (flag !== 32'h0) begin errors++; $display("FAIL idle_flag got=%h exp=0", flag); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL idle_result got=%0d exp=0", result); end
        checks++; if (n1_flag !== 32'h0) begin errors++; $display("FAIL idle_n1_flag got=%h exp=0", n1_flag); end
    endtask

    initial begin
        rst = 1'b1;
        en1 = 1'b0;
        en2 = 1'b0;
        #2;
        test_reset();
        test_basic();
        test_stall_hart2();
        test_toggle_hart1();
        test_mid_reset();
        test_write_abort();
        test_single_term();
        test_idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
